// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//   Instruction prefetch queue between instruction memory and the fetch/decode
//   register. A small FSM (IDLE/REQ/DROP) issues sequential word fetches into
//   a DEPTH-entry circular FIFO of {pc, instr} pairs. An execute-stage
//   redirect flushes the queue and restarts fetching at the branch target;
//   a response still in flight at redirect time is discarded (DROP).
//
// Parameters
//   DEPTH     queue entries, power of two, >= 2
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   imem_req     out  instruction-memory read request
//   imem_addr    out  word address of the outstanding request
//   imem_ack     in   request complete, imem_rdata valid this cycle
//   imem_rdata   in   instruction word
//   redirect     in   branch/jump taken in execute (PCSrcE)
//   redirect_pc  in   new fetch address (PCTargetE)
//   stall        in   downstream fetch/decode register not accepting
//   valid        out  InstrF/PCF hold a real queued instruction
//   InstrF       out  queue-head instruction (NOP when empty)
//   PCF          out  queue-head PC (0 when empty)
//
// Optional feature (macro IPQ_PERF_EN)
//   perf_redirect_cnt  out  16-bit saturating count of redirect cycles
//   perf_drop_cnt      out  16-bit saturating count of discarded acks
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        valid,
   output logic [31:0] InstrF,
   output logic [31:0] PCF
`ifdef IPQ_PERF_EN
   ,
   output logic [15:0] perf_redirect_cnt,
   output logic [15:0] perf_drop_cnt
`endif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DROP
   } stateT;

   stateT          state;
   logic [CW-1:0]  count;
   logic [CW-1:0]  countNext;
   logic [PW-1:0]  rdPtr;
   logic [PW-1:0]  wrPtr;
   logic [31:0]    fetchPc;
   logic [31:0]    fetchPcInc;
   logic [31:0]    reqAddr;
   logic           push;
   logic           pop;
   logic           roomNext;

   logic [31:0]    pcMem    [DEPTH];
   logic [31:0]    instrMem [DEPTH];

   // A push only happens in REQ and only when no redirect is flushing the
   // queue; requests are issued only with a slot reserved, so it cannot
   // overflow.
   always_comb begin
      push       = (state == REQ) && imem_ack && !redirect;
      pop        = (count != '0) && !stall;
      fetchPcInc = fetchPc + 32'd4;
      countNext  = count;
      if (push && !pop) begin
         countNext = count + CW'(1);
      end else if (!push && pop) begin
         countNext = count - CW'(1);
      end
      roomNext   = (countNext < CW'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         rdPtr   <= '0;
         wrPtr   <= '0;
         fetchPc <= RESET_PC;
         reqAddr <= RESET_PC;
      end else if (redirect) begin
         // Flush dominates push/pop; an outstanding request without its ack
         // must still be completed on the bus, so it is drained in DROP.
         count   <= '0;
         rdPtr   <= '0;
         wrPtr   <= '0;
         fetchPc <= redirect_pc;
         case (state)
            REQ:     state <= imem_ack ? IDLE : DROP;
            DROP:    state <= DROP;
            default: state <= IDLE;
         endcase
      end else begin
         count <= countNext;
         if (push) begin
            wrPtr   <= wrPtr + PW'(1);
            fetchPc <= fetchPcInc;
         end
         if (pop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         case (state)
            IDLE: begin
               if (roomNext) begin
                  reqAddr <= fetchPc;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  if (roomNext) begin
                     reqAddr <= fetchPcInc;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DROP: begin
               if (imem_ack) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         pcMem[wrPtr]    <= reqAddr;
         instrMem[wrPtr] <= imem_rdata;
      end
   end

   always_comb begin
      imem_req  = (state != IDLE);
      imem_addr = reqAddr;
      valid     = (count != '0);
      InstrF    = NOP;
      PCF       = '0;
      if (valid) begin
         InstrF = instrMem[rdPtr];
         PCF    = pcMem[rdPtr];
      end
   end

`ifdef IPQ_PERF_EN
   logic dropAck;

   // An ack is discarded when it races a redirect in REQ or arrives in DROP.
   always_comb begin
      dropAck = imem_ack && (((state == REQ) && redirect) || (state == DROP));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_redirect_cnt <= '0;
         perf_drop_cnt     <= '0;
      end else begin
         if (redirect && (perf_redirect_cnt != '1)) begin
            perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
         end
         if (dropAck && (perf_drop_cnt != '1)) begin
            perf_drop_cnt <= perf_drop_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//   Directed bench for instr_prefetch_queue (DEPTH=4, RESET_PC=0). The memory
//   responder returns ~addr as the instruction word and acks after a
//   programmable number of wait cycles (0 = same cycle as the request).
//   Perf counter checks are compiled only when IPQ_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        valid;
   logic [31:0] InstrF;
   logic [31:0] PCF;
`ifdef IPQ_PERF_EN
   logic [15:0] perf_redirect_cnt;
   logic [15:0] perf_drop_cnt;
`endif

   logic        memEn;
   logic        ackOvr;
   int unsigned lat;
   int unsigned waitCnt = 0;
   int          checks  = 0;
   int          passes  = 0;

   instr_prefetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ack          (imem_ack),
      .imem_rdata        (imem_rdata),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .stall             (stall),
      .valid             (valid),
      .InstrF            (InstrF),
      .PCF               (PCF)
`ifdef IPQ_PERF_EN
      ,
      .perf_redirect_cnt (perf_redirect_cnt),
      .perf_drop_cnt     (perf_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   assign imem_rdata = ~imem_addr;
   assign imem_ack   = ackOvr | (memEn && imem_req && (waitCnt == lat));

   always @(posedge clk) begin
      if (!imem_req || imem_ack) waitCnt <= 0;
      else                       waitCnt <= waitCnt + 1;
   end

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in "cycle 0": registers hold reset values, reset low.
   task automatic applyReset;
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;
      memEn       = 1'b0;
      ackOvr      = 1'b0;
      lat         = 0;
      nextCycle();
      nextCycle();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      applyReset();
      @(negedge clk);
      checks++;
      if ({imem_req, valid} !== 2'b00) $display("FAIL reset_req_valid got %b exp 00", {imem_req, valid});
      else passes++;
      checks++;
      if (InstrF !== 32'h13) $display("FAIL reset_instr got %h exp 00000013", InstrF);
      else passes++;
      checks++;
      if (PCF !== 32'h0) $display("FAIL reset_pcf got %h exp 00000000", PCF);
      else passes++;
`ifdef IPQ_PERF_EN
      checks++;
      if ({perf_redirect_cnt, perf_drop_cnt} !== 32'h0) $display("FAIL reset_perf got %h exp 0", {perf_redirect_cnt, perf_drop_cnt});
      else passes++;
`endif
   endtask

   task automatic test_stream;
      logic [31:0] e;
      applyReset();
      memEn = 1'b1;
      lat   = 0;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) $display("FAIL stream_c0_req got %b exp 0", imem_req);
      else passes++;
      nextCycle();
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL stream_c1_req got %h exp 100000000", {imem_req, imem_addr});
      else passes++;
      for (int i = 0; i < 6; i++) begin
         nextCycle();
         @(negedge clk);
         e = 32'(4 * i);
         checks++;
         if ({valid, PCF, InstrF} !== {1'b1, e, ~e})
            $display("FAIL stream_head%0d got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h", i, valid, PCF, InstrF, e, ~e);
         else passes++;
      end
   endtask

   task automatic test_stall_fill;
      int          pushes;
      logic [31:0] e;
      applyReset();
      memEn  = 1'b1;
      lat    = 0;
      stall  = 1'b1;
      pushes = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req && imem_ack) pushes++;
         nextCycle();
      end
      checks++;
      if (pushes !== 4) $display("FAIL fill_pushes got %0d exp 4", pushes);
      else passes++;
      stall = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         e = 32'(4 * k);
         if (k == 0) begin
            checks++;
            if (imem_req !== 1'b0) $display("FAIL fill_full_req got %b exp 0", imem_req);
            else passes++;
         end
         if (k == 1) begin
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h10}) $display("FAIL fill_resume got %h exp 100000010", {imem_req, imem_addr});
            else passes++;
         end
         checks++;
         if ({valid, PCF, InstrF} !== {1'b1, e, ~e})
            $display("FAIL fill_order%0d got v=%b pc=%h ins=%h exp v=1 pc=%h", k, valid, PCF, InstrF, e);
         else passes++;
         nextCycle();
      end
   endtask

   task automatic test_redirect_drop;
      applyReset();
      memEn       = 1'b1;
      lat         = 3;
      stall       = 1'b1;
      redirect_pc = 32'h100;
      for (int c = 0; c <= 14; c++) begin
         redirect = (c == 6);
         @(negedge clk);
         case (c)
            5: begin
               checks++;
               if ({valid, PCF} !== {1'b1, 32'h0}) $display("FAIL drop_pre got %h exp 100000000", {valid, PCF});
               else passes++;
            end
            7: begin
               checks++;
               if ({valid, imem_req, imem_addr} !== {2'b01, 32'h4}) $display("FAIL drop_flush got %h exp 100000004", {valid, imem_req, imem_addr});
               else passes++;
            end
            8: begin
               checks++;
               if ({imem_req, imem_ack, imem_addr} !== {2'b11, 32'h4}) $display("FAIL drop_hold got %h exp 300000004", {imem_req, imem_ack, imem_addr});
               else passes++;
            end
            9: begin
               checks++;
               if ({imem_req, valid} !== 2'b00) $display("FAIL drop_idle got %b exp 00", {imem_req, valid});
               else passes++;
            end
            10: begin
               checks++;
               if ({imem_req, imem_addr} !== {1'b1, 32'h100}) $display("FAIL drop_newreq got %h exp 100000100", {imem_req, imem_addr});
               else passes++;
            end
            13: begin
               checks++;
               if (valid !== 1'b0) $display("FAIL drop_latency got %b exp 0", valid);
               else passes++;
            end
            14: begin
               checks++;
               if ({valid, PCF, InstrF} !== {1'b1, 32'h100, ~32'h100}) $display("FAIL drop_first got v=%b pc=%h ins=%h exp v=1 pc=00000100", valid, PCF, InstrF);
               else passes++;
            end
            default: ;
         endcase
         nextCycle();
      end
      redirect = 1'b0;
`ifdef IPQ_PERF_EN
      checks++;
      if ({perf_redirect_cnt, perf_drop_cnt} !== {16'd1, 16'd1}) $display("FAIL drop_perf got %h exp 00010001", {perf_redirect_cnt, perf_drop_cnt});
      else passes++;
`endif
   endtask

   task automatic test_redirect_with_ack;
      applyReset();
      memEn       = 1'b1;
      lat         = 0;
      stall       = 1'b1;
      redirect_pc = 32'h100;
      for (int c = 0; c <= 9; c++) begin
         redirect = (c == 3);
         @(negedge clk);
         case (c)
            2: begin
               checks++;
               if ({valid, PCF} !== {1'b1, 32'h0}) $display("FAIL rack_pre got %h exp 100000000", {valid, PCF});
               else passes++;
            end
            3: begin
               checks++;
               if ({imem_req, imem_ack, imem_addr} !== {2'b11, 32'h8}) $display("FAIL rack_addr8 got %h exp 300000008", {imem_req, imem_ack, imem_addr});
               else passes++;
            end
            4: begin
               checks++;
               if ({imem_req, valid} !== 2'b00) $display("FAIL rack_idle got %b exp 00", {imem_req, valid});
               else passes++;
            end
            5: begin
               checks++;
               if ({imem_req, imem_addr} !== {1'b1, 32'h100}) $display("FAIL rack_newreq got %h exp 100000100", {imem_req, imem_addr});
               else passes++;
            end
            6: begin
               checks++;
               if ({valid, PCF} !== {1'b1, 32'h100}) $display("FAIL rack_first got %h exp 100000100", {valid, PCF});
               else passes++;
            end
            9: begin
               checks++;
               if ({imem_req, valid, PCF} !== {2'b01, 32'h100}) $display("FAIL rack_full got %h exp 100000100", {imem_req, valid, PCF});
               else passes++;
            end
            default: ;
         endcase
         nextCycle();
      end
      redirect = 1'b0;
`ifdef IPQ_PERF_EN
      checks++;
      if ({perf_redirect_cnt, perf_drop_cnt} !== {16'd1, 16'd1}) $display("FAIL rack_perf got %h exp 00010001", {perf_redirect_cnt, perf_drop_cnt});
      else passes++;
`endif
   endtask

   task automatic test_reset_mid_req;
      applyReset();
      memEn = 1'b1;
      lat   = 0;
      stall = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         case (c)
            3: memEn = 1'b0;
            4: reset = 1'b1;
            5: begin reset = 1'b0; ackOvr = 1'b1; end
            6: begin ackOvr = 1'b0; memEn = 1'b1; end
            default: ;
         endcase
         @(negedge clk);
         case (c)
            3: begin
               checks++;
               if ({imem_req, imem_ack, imem_addr} !== {2'b10, 32'h8}) $display("FAIL rmid_pending got %h exp 200000008", {imem_req, imem_ack, imem_addr});
               else passes++;
            end
            5: begin
               checks++;
               if ({imem_req, valid, InstrF, PCF} !== {2'b00, 32'h13, 32'h0}) $display("FAIL rmid_after got %h exp 0000000130000000", {imem_req, valid, InstrF, PCF});
               else passes++;
            end
            6: begin
               checks++;
               if ({imem_req, valid, imem_addr} !== {2'b10, 32'h0}) $display("FAIL rmid_restart got %h exp 200000000", {imem_req, valid, imem_addr});
               else passes++;
            end
            7: begin
               checks++;
               if ({valid, PCF, InstrF} !== {1'b1, 32'h0, 32'hFFFF_FFFF}) $display("FAIL rmid_first got v=%b pc=%h ins=%h exp v=1 pc=0 ins=ffffffff", valid, PCF, InstrF);
               else passes++;
            end
            default: ;
         endcase
         nextCycle();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;
      memEn       = 1'b0;
      ackOvr      = 1'b0;
      lat         = 0;
      test_reset();
      test_stream();
      test_stall_fill();
      test_redirect_drop();
      test_redirect_with_ack();
      test_reset_mid_req();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 imem_req  out  1  instruction-memory read request.
REQ-006 imem_addr  out  32  word address of the outstanding request.
REQ-007 imem_ack  in  1  request complete; imem_rdata valid this cycle.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 redirect  in  1  execute-stage branch/jump taken (PCSrcE).
REQ-010 redirect_pc  in  32  new fetch address (PCTargetE).
REQ-011 stall  in  1  downstream fetch/decode register not accepting.
REQ-012 valid  out  1  InstrF/PCF hold a real queued instruction.
REQ-013 InstrF  out  32  queue-head instruction.
REQ-014 PCF  out  32  queue-head PC.

Function
REQ-015 Queue entries SHALL be {pc, instr} pairs in a DEPTH-entry circular FIFO with wrapping read/write pointers and a count of 0..DEPTH.
REQ-016 The FSM SHALL have states IDLE (req=0), REQ (req=1), and DROP (req=1, response discarded).
REQ-017 In IDLE with no redirect and count_next < DEPTH, the FSM SHALL load req_addr <= fetch_pc and go to REQ.
REQ-018 In REQ and DROP, imem_req SHALL be 1 and imem_addr = req_addr, held stable until imem_ack.
REQ-019 On ack in REQ, the block SHALL push {req_addr, imem_rdata} and set fetch_pc <= fetch_pc + 4 (mod 2^32).
REQ-020 After that push, if count_next < DEPTH, the FSM SHALL stay in REQ with req_addr <= fetch_pc + 4; otherwise it SHALL go to IDLE.
REQ-021 A request SHALL be issued only when a slot is reserved, so a push SHALL never overflow.
REQ-022 Pop SHALL occur when valid && !stall; simultaneous push and pop SHALL leave count unchanged.
REQ-023 valid SHALL equal (count != 0); when valid=0, InstrF SHALL be 32'h0000_0013 (NOP) and PCF 32'h0.
REQ-024 Redirect SHALL have priority over push, pop, and the FSM: count <= 0 and fetch_pc <= redirect_pc.
REQ-025 On redirect in REQ without ack, the FSM SHALL go to DROP; with ack, or in IDLE, it SHALL go to IDLE; ack data SHALL never be pushed.
REQ-026 In DROP, the ack SHALL be consumed without a push, and the FSM SHALL then go to IDLE; a redirect while in DROP SHALL stay in DROP.
REQ-027 An imem_ack received in IDLE SHALL be ignored.
REQ-028 Latency from ack to valid SHALL be 1 cycle; valid SHALL be 0 the cycle after a redirect.

Reset
REQ-029 On reset: state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, req_addr=RESET_PC.
REQ-030 Outputs the cycle after reset: imem_req=0, valid=0, InstrF=32'h13, PCF=0.
REQ-031 Reset mid-request SHALL abandon the request; a later stray ack is ignored per REQ-027.

Configuration
REQ-032 With IPQ_PERF_EN defined, the block SHALL add output perf_redirect_cnt (16 bits), incremented per redirect cycle, saturating at 16'hFFFF, cleared by reset.
REQ-033 With IPQ_PERF_EN defined, the block SHALL add output perf_drop_cnt (16 bits), incremented per discarded ack (REQ-025/026), saturating at 16'hFFFF, cleared by reset.
REQ-034 Without IPQ_PERF_EN, neither counter nor its port SHALL exist, and behaviour SHALL otherwise be identical.

Verification
REQ-035 Reset release, zero-wait ack, stall=0 -> req cycle 1 addr 0x0; valid cycle 2 PCF=0x0; PCF then 0x4, 0x8, ... one per cycle.
REQ-036 DEPTH=4, stall=1, zero-wait ack -> exactly 4 pushes, then imem_req=0; PCF held 0x0; stall=0 -> refill resumes at 0x10.
REQ-037 3-cycle ack latency, redirect_pc=0x100 mid-REQ -> valid=0 next cycle; DROP holds old addr until ack; next req addr 0x100; first valid PCF=0x100.
REQ-038 Redirect in the same cycle as ack (addr 0x8) -> no push; next req addr 0x100; perf_drop_cnt+1 (if enabled).
REQ-039 count=3, DEPTH=4, push+pop same cycle -> count stays 3, FIFO order preserved across pointer wrap.
REQ-040 reset asserted in REQ, ack one cycle later -> imem_req=0, valid=0, no push, next req addr RESET_PC.
